// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared core types for the branch target buffer path.
//   ADDR_WIDTH       - architectural address width
//   BTB_INDEX_WIDTH  - BTB set index bits (2**BTB_INDEX_WIDTH sets)
//   BTB_TAG_WIDTH    - tag bits above index and word offset
//   BTB_WAYS         - BTB associativity
//   BranchOutcome    - resolved branch direction
//   btb_update_t     - one pending BTB allocation {index, tag, target}
//   btb_ctrl_state_e - update-controller FSM states
package mips_core_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int BTB_INDEX_WIDTH = 4;
  localparam int BTB_TAG_WIDTH   = ADDR_WIDTH - BTB_INDEX_WIDTH - 2;
  localparam int BTB_WAYS        = 2;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef struct packed {
    logic [BTB_INDEX_WIDTH-1:0] index;
    logic [BTB_TAG_WIDTH-1:0]   tag;
    logic [ADDR_WIDTH-1:0]      target;
  } btb_update_t;

  typedef enum logic {
    S_SWEEP = 1'b0,
    S_RUN   = 1'b1
  } btb_ctrl_state_e;

endpackage

// File: rtl/btb_update_if.sv
// btb_update_if: feedback handshake plus BTB write bus.
//   i_fb_valid/i_fb_pc/i_fb_target/i_fb_outcome/o_fb_ready - resolved branch feedback
//   o_we/o_waddr/o_wtag/o_wtarget/o_wvalid                 - BTB write port
// modport master: feedback source / BTB array side.
// modport slave : the update controller.
interface btb_update_if
  import mips_core_pkg::*;
#(
  parameter int INDEX_WIDTH   = BTB_INDEX_WIDTH,
  parameter int ASSOCIATIVITY = BTB_WAYS
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

  logic                     i_fb_valid;
  logic [ADDR_WIDTH-1:0]    i_fb_pc;
  logic [ADDR_WIDTH-1:0]    i_fb_target;
  BranchOutcome             i_fb_outcome;
  logic                     o_fb_ready;

  logic [ASSOCIATIVITY-1:0] o_we;
  logic [INDEX_WIDTH-1:0]   o_waddr;
  logic [TAG_WIDTH-1:0]     o_wtag;
  logic [ADDR_WIDTH-1:0]    o_wtarget;
  logic                     o_wvalid;

  modport master (
    output i_fb_valid, i_fb_pc, i_fb_target, i_fb_outcome,
    input  o_fb_ready, o_we, o_waddr, o_wtag, o_wtarget, o_wvalid
  );

  modport slave (
    input  i_fb_valid, i_fb_pc, i_fb_target, i_fb_outcome,
    output o_fb_ready, o_we, o_waddr, o_wtag, o_wtarget, o_wvalid
  );

endinterface

// File: rtl/btb_update_fifo.sv
// btb_update_fifo: small queue of pending BTB allocations.
//   clk, rst_n  - clock, synchronous active-low reset (empties the queue)
//   clr         - synchronous empty request (flush)
//   push, din   - enqueue when not full
//   pop, dout   - dequeue when not empty; dout shows the head combinationally
//   full, empty - occupancy flags
// The head is read straight from the storage array so that an entry pushed in
// one cycle can be written to the BTB in the very next cycle.
module btb_update_fifo
  import mips_core_pkg::*;
#(
  parameter int DEPTH = 4  // power of two, >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  btb_update_t din,
  input  logic        pop,
  output btb_update_t dout,
  output logic        full,
  output logic        empty
);
  // One extra pointer bit distinguishes full from empty when addresses match.
  localparam int PTR_W = $clog2(DEPTH) + 1;

  btb_update_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  always_comb begin
    full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
              (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    empty   = (wr_ptr_q == rd_ptr_q);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    dout    = mem[rd_ptr_q[PTR_W-2:0]];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr_q[PTR_W-2:0]] <= din;
  end

endmodule

// File: rtl/btb_update_controller.sv
// btb_update_controller: turns resolved-branch feedback into BTB writes.
//   clk, rst_n      - clock, synchronous active-low reset
//   i_flush_req     - one-cycle request to invalidate the whole BTB
//   o_busy          - invalidation sweep in progress
//   o_update_count  - saturating count of allocating writes issued
//   bus (slave)     - feedback handshake and BTB write port
// After reset or a flush every set is invalidated (both ways) one index per
// cycle. Afterwards, taken feedback is queued and each queued entry is written
// into the way selected by a per-set toggle bit, one write per cycle.
module btb_update_controller
  import mips_core_pkg::*;
#(
  parameter int INDEX_WIDTH   = BTB_INDEX_WIDTH,
  parameter int FIFO_DEPTH    = 4,
  parameter int ASSOCIATIVITY = BTB_WAYS  // only 2 is supported
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush_req,
  output logic         o_busy,
  output logic [15:0]  o_update_count,
  btb_update_if.slave  bus
);
  localparam int DEPTH = 1 << INDEX_WIDTH;

  btb_ctrl_state_e        state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [DEPTH-1:0]       repl_q, repl_d;
  logic [15:0]            count_q, count_d;

  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  btb_update_t fifo_din, fifo_head;

  assign fifo_din = '{index:  bus.i_fb_pc[INDEX_WIDTH+1:2],
                      tag:    bus.i_fb_pc[ADDR_WIDTH-1:INDEX_WIDTH+2],
                      target: bus.i_fb_target};

  btb_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (i_flush_req),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_SWEEP;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SWEEP: if (!i_flush_req && sweep_cnt_q == INDEX_WIDTH'(DEPTH - 1)) state_d = S_RUN;
      S_RUN:   if (i_flush_req) state_d = S_SWEEP;
      default: state_d = S_SWEEP;
    endcase
  end

  // Output logic
  always_comb begin
    bus.o_fb_ready = (state_q == S_RUN) && !fifo_full && !i_flush_req;
    fifo_push      = bus.i_fb_valid && bus.o_fb_ready && (bus.i_fb_outcome == TAKEN);
    fifo_pop       = (state_q == S_RUN) && !fifo_empty && !i_flush_req;
    o_busy         = (state_q == S_SWEEP);

    bus.o_we      = '0;
    bus.o_waddr   = '0;
    bus.o_wtag    = '0;
    bus.o_wtarget = '0;
    bus.o_wvalid  = 1'b0;
    if (state_q == S_SWEEP) begin
      bus.o_we    = '1;
      bus.o_waddr = sweep_cnt_q;
    end else if (fifo_pop) begin
      bus.o_we[repl_q[fifo_head.index]] = 1'b1;
      bus.o_waddr   = fifo_head.index;
      bus.o_wtag    = fifo_head.tag;
      bus.o_wtarget = fifo_head.target;
      bus.o_wvalid  = 1'b1;
    end
  end

  // Counters. The sweep counter idles at 0 in S_RUN so a flush always
  // restarts from index 0; DEPTH-1 + 1 wraps back to 0 on its own.
  always_comb begin
    sweep_cnt_d = '0;
    if (state_q == S_SWEEP && !i_flush_req) sweep_cnt_d = sweep_cnt_q + 1'b1;
    count_d = count_q;
    if (fifo_pop && count_q != 16'hFFFF) count_d = count_q + 16'd1;
  end

  // Per-set replacement bit: cleared by the sweep, toggled on each allocation.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_repl
      assign repl_d[gi] = (state_q == S_SWEEP)
                        ? ((sweep_cnt_q == INDEX_WIDTH'(gi)) ? 1'b0 : repl_q[gi])
                        : ((fifo_pop && fifo_head.index == INDEX_WIDTH'(gi)) ? ~repl_q[gi]
                                                                             : repl_q[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sweep_cnt_q <= '0;
      repl_q      <= '0;
      count_q     <= '0;
    end else begin
      sweep_cnt_q <= sweep_cnt_d;
      repl_q      <= repl_d;
      count_q     <= count_d;
    end
  end

  assign o_update_count = count_q;

endmodule
